// File: rtl/throw_pkg.sv
// Shared types and default trajectory constants for the throw X/Y generators.
package throw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } throw_state_t;

    localparam int Y_IDLE_DEF     = 768;
    localparam int Y_LAUNCH_DEF   = 454;
    localparam int Y_GROUND_DEF   = 768;
    localparam int SPEED_DEF_DEF  = 20;
    localparam int SPEED_MAX_DEF  = 40;
    localparam int UP_TICKS_DEF   = 250000;
    localparam int DOWN_TICKS_DEF = 100000;

    // Counter width able to hold max(a, b) - 1, never narrower than one bit.
    function automatic int tick_cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running step counter: tick is high in the cycle where the count equals period.
module tick_divider #(
    parameter int MAX_W = 18
) (
    input  logic             clk60MHz,
    input  logic             rst,
    input  logic             clr,
    input  logic [MAX_W-1:0] period,
    output logic             tick
);

    logic [MAX_W-1:0] cnt;

    assign tick = !clr && (cnt == period);

    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/throw_ypos_gen.sv
// Vertical trajectory of a thrown object: decelerating rise, apex, accelerating fall
// clamped at the ground line. state_dbg exposes the FSM for checkers.
module throw_ypos_gen
    import throw_pkg::*;
#(
    parameter int Y_W        = 12,
    parameter int SPD_W      = 6,
    parameter int Y_IDLE     = Y_IDLE_DEF,
    parameter int Y_LAUNCH   = Y_LAUNCH_DEF,
    parameter int Y_GROUND   = Y_GROUND_DEF,
    parameter int SPEED_DEF  = SPEED_DEF_DEF,
    parameter int SPEED_MAX  = SPEED_MAX_DEF,
    parameter int UP_TICKS   = UP_TICKS_DEF,
    parameter int DOWN_TICKS = DOWN_TICKS_DEF
) (
    input  logic             clk60MHz,
    input  logic             rst,
    input  logic             start,
    input  logic [SPD_W-1:0] speed_init,
    input  logic             abort,
    output logic [Y_W-1:0]   ypos,
    output logic             busy,
    output logic             apex,
    output logic             landed,
    output throw_state_t     state_dbg
);

    localparam int CNT_W = tick_cnt_w(UP_TICKS, DOWN_TICKS);
    localparam int YS_W  = Y_W + 1;

    localparam logic [Y_W-1:0]   Y_IDLE_V    = Y_W'(Y_IDLE);
    localparam logic [Y_W-1:0]   Y_LAUNCH_V  = Y_W'(Y_LAUNCH);
    localparam logic [Y_W-1:0]   Y_GROUND_V  = Y_W'(Y_GROUND);
    localparam logic [YS_W-1:0]  Y_GROUND_S  = YS_W'(Y_GROUND);
    localparam logic [SPD_W-1:0] SPEED_DEF_V = SPD_W'(SPEED_DEF);
    localparam logic [SPD_W-1:0] SPEED_MAX_V = SPD_W'(SPEED_MAX);
    localparam logic [CNT_W-1:0] UP_PER      = CNT_W'(UP_TICKS - 1);
    localparam logic [CNT_W-1:0] DOWN_PER    = CNT_W'(DOWN_TICKS - 1);

    throw_state_t     state;
    logic [SPD_W-1:0] speed;
    logic [SPD_W-1:0] speed_base;
    logic [SPD_W-1:0] speed_sel;
    logic [Y_W-1:0]   speed_y;
    logic [YS_W-1:0]  fall_sum;
    logic [CNT_W-1:0] period;
    logic             clr;
    logic             tick;

    // The counter only runs while airborne; abort restarts it from zero.
    assign clr        = abort || !(state == RISE || state == FALL);
    assign period     = (state == FALL) ? DOWN_PER : UP_PER;
    assign speed_base = (speed_init == '0) ? SPEED_DEF_V : speed_init;
    assign speed_sel  = (speed_base > SPEED_MAX_V) ? SPEED_MAX_V : speed_base;
    assign speed_y    = Y_W'(speed);
    assign fall_sum   = {1'b0, ypos} + YS_W'(speed);
    assign state_dbg  = state;

    tick_divider #(
        .MAX_W (CNT_W)
    ) u_tick (
        .clk60MHz (clk60MHz),
        .rst      (rst),
        .clr      (clr),
        .period   (period),
        .tick     (tick)
    );

    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ypos   <= Y_IDLE_V;
            speed  <= SPEED_DEF_V;
            busy   <= 1'b0;
            apex   <= 1'b0;
            landed <= 1'b0;
        end else begin
            apex   <= 1'b0;
            landed <= 1'b0;
            if (abort) begin
                state <= IDLE;
                ypos  <= Y_IDLE_V;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        ypos <= Y_IDLE_V;
                        if (start) begin
                            state <= RISE;
                            ypos  <= Y_LAUNCH_V;
                            speed <= speed_sel;
                            busy  <= 1'b1;
                        end
                    end
                    RISE: begin
                        if (tick) begin
                            if (speed > SPD_W'(1)) begin
                                ypos  <= (ypos > speed_y) ? ypos - speed_y : '0;
                                speed <= speed - 1'b1;
                            end else begin
                                state <= FALL;
                                apex  <= 1'b1;
                            end
                        end
                    end
                    FALL: begin
                        if (tick) begin
                            if (fall_sum >= Y_GROUND_S) begin
                                state  <= IDLE;
                                ypos   <= Y_GROUND_V;
                                busy   <= 1'b0;
                                landed <= 1'b1;
                            end else begin
                                ypos  <= fall_sum[Y_W-1:0];
                                speed <= (speed >= SPEED_MAX_V) ? SPEED_MAX_V : speed + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        ypos  <= Y_IDLE_V;
                        speed <= SPEED_DEF_V;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_throw_ypos_gen.sv
// Directed bench for throw_ypos_gen: table of hand-computed vectors on a fast-tick
// instance plus hand sequences for reset, saturation and fall-speed clamping.
module tb_throw_ypos_gen;
    import throw_pkg::*;

    logic clk60MHz = 1'b0;
    logic rst;

    logic        start_a, abort_a;
    logic [5:0]  spd_a;
    logic [11:0] ypos_a;
    logic        busy_a, apex_a, landed_a;
    throw_state_t st_a;

    logic        start_b, abort_b;
    logic [5:0]  spd_b;
    logic [11:0] ypos_b;
    logic        busy_b, apex_b, landed_b;
    throw_state_t st_b;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic        start;
        logic [5:0]  spd;
        logic        abrt;
        int          wait_n;
        logic [11:0] y;
        logic        bsy;
        logic        apx;
        logic        lnd;
    } vec_t;

    vec_t vecs[$];

    // ---------------- clock / reset ----------------
    always #5 clk60MHz = ~clk60MHz;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    throw_ypos_gen #(
        .UP_TICKS   (4),
        .DOWN_TICKS (2)
    ) u_dut_a (
        .clk60MHz   (clk60MHz),
        .rst        (rst),
        .start      (start_a),
        .speed_init (spd_a),
        .abort      (abort_a),
        .ypos       (ypos_a),
        .busy       (busy_a),
        .apex       (apex_a),
        .landed     (landed_a),
        .state_dbg  (st_a)
    );

    throw_ypos_gen #(
        .Y_LAUNCH   (10),
        .Y_GROUND   (2000),
        .UP_TICKS   (2),
        .DOWN_TICKS (1)
    ) u_dut_b (
        .clk60MHz   (clk60MHz),
        .rst        (rst),
        .start      (start_b),
        .speed_init (spd_b),
        .abort      (abort_b),
        .ypos       (ypos_b),
        .busy       (busy_b),
        .apex       (apex_b),
        .landed     (landed_b),
        .state_dbg  (st_b)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic add(input logic st, input logic [5:0] sp, input logic ab, input int w,
                       input logic [11:0] y, input logic bs, input logic ap, input logic ld);
        vec_t v;
        v.start = st; v.spd = sp; v.abrt = ab; v.wait_n = w;
        v.y = y; v.bsy = bs; v.apx = ap; v.lnd = ld;
        vecs.push_back(v);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int fall_y[24];
        int fall_bad;
        int max_delta;
        int exp_y;
        logic [11:0] prev_y;
        logic [11:0] worst;
        logic [11:0] idle_seen;

        fall_y = '{450, 452, 455, 459, 464, 470, 477, 485, 494, 504, 515, 527,
                   540, 554, 569, 585, 602, 620, 639, 659, 680, 702, 725, 749};

        // Nominal arc with speed 3, plus a second start during RISE that must be ignored.
        add(1, 3, 0, 1, 454, 1, 0, 0);
        add(0, 3, 0, 3, 454, 1, 0, 0);
        add(0, 3, 0, 1, 451, 1, 0, 0);
        add(1, 5, 0, 3, 451, 1, 0, 0);
        add(0, 5, 0, 1, 449, 1, 0, 0);
        add(0, 0, 0, 4, 449, 1, 1, 0);
        add(0, 0, 0, 1, 449, 1, 0, 0);
        for (int i = 0; i < 24; i++) add(0, 0, 0, (i == 0) ? 1 : 2, 12'(fall_y[i]), 1, 0, 0);
        add(0, 0, 0, 2, 768, 0, 0, 1);
        add(0, 0, 0, 1, 768, 0, 0, 0);
        // Abort in FALL coincident with a tick.
        add(1, 3, 0, 1, 454, 1, 0, 0);
        add(0, 3, 0, 14, 450, 1, 0, 0);
        add(0, 3, 0, 1, 450, 1, 0, 0);
        add(0, 3, 1, 1, 768, 0, 0, 0);
        add(0, 3, 0, 1, 768, 0, 0, 0);
        add(0, 3, 0, 3, 768, 0, 0, 0);
        // abort and start together in IDLE.
        add(1, 3, 1, 1, 768, 0, 0, 0);
        add(0, 3, 0, 1, 768, 0, 0, 0);
        add(0, 3, 0, 4, 768, 0, 0, 0);
        // speed_init = 0 selects the default speed 20.
        add(1, 0, 0, 1, 454, 1, 0, 0);
        add(0, 0, 0, 4, 434, 1, 0, 0);
        add(0, 0, 0, 4, 415, 1, 0, 0);
        add(0, 0, 1, 1, 768, 0, 0, 0);
        add(0, 0, 0, 1, 768, 0, 0, 0);
        // speed_init = 63 clamps to 40.
        add(1, 63, 0, 1, 454, 1, 0, 0);
        add(0, 63, 0, 4, 414, 1, 0, 0);
        add(0, 63, 0, 4, 375, 1, 0, 0);
        add(0, 63, 1, 1, 768, 0, 0, 0);
        add(0, 63, 0, 1, 768, 0, 0, 0);

        rst = 1'b1;
        start_a = 0; abort_a = 0; spd_a = '0;
        start_b = 0; abort_b = 0; spd_b = '0;
        repeat (3) @(negedge clk60MHz);
        check("rst_ypos_a", ypos_a, 768);
        check("rst_busy_a", busy_a, 0);
        check("rst_apex_a", apex_a, 0);
        check("rst_landed_a", landed_a, 0);
        check("rst_state_a", st_a, IDLE);
        check("rst_ypos_b", ypos_b, 768);
        rst = 1'b0;
        repeat (2) @(negedge clk60MHz);
        check("idle_ypos_a", ypos_a, 768);

        // ---- table-driven vectors on instance A ----
        foreach (vecs[i]) begin
            start_a = vecs[i].start;
            spd_a   = vecs[i].spd;
            abort_a = vecs[i].abrt;
            repeat (vecs[i].wait_n) @(negedge clk60MHz);
            check($sformatf("v%0d_ypos", i), ypos_a, vecs[i].y);
            check($sformatf("v%0d_busy", i), busy_a, vecs[i].bsy);
            check($sformatf("v%0d_apex", i), apex_a, vecs[i].apx);
            check($sformatf("v%0d_landed", i), landed_a, vecs[i].lnd);
        end
        start_a = 0; abort_a = 0;

        // ---- reset asserted mid-RISE ----
        start_a = 1; spd_a = 3;
        @(negedge clk60MHz);
        start_a = 0;
        repeat (4) @(negedge clk60MHz);
        check("midrise_ypos", ypos_a, 451);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ypos", ypos_a, 768);
        check("async_rst_busy", busy_a, 0);
        @(negedge clk60MHz);
        rst = 1'b0;
        idle_seen = 12'd768;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk60MHz);
            if (ypos_a !== 12'd768 || busy_a !== 1'b0) idle_seen = ypos_a;
        end
        check("idle_hold_ypos", idle_seen, 768);
        check("idle_hold_state", st_a, IDLE);

        // ---- saturation and fall-speed clamp on instance B ----
        start_b = 1; spd_b = 20;
        @(negedge clk60MHz);
        start_b = 0;
        check("sat_launch", ypos_b, 10);
        @(negedge clk60MHz);
        check("sat_pre_tick", ypos_b, 10);
        @(negedge clk60MHz);
        check("sat_first_step", ypos_b, 0);
        worst = ypos_b;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk60MHz);
            if (ypos_b > worst) worst = ypos_b;
            if (apex_b) worst = 12'hfff;
        end
        check("sat_rise_max", worst, 0);
        @(negedge clk60MHz);
        check("sat_before_apex", apex_b, 0);
        @(negedge clk60MHz);
        check("sat_apex", apex_b, 1);
        check("sat_apex_ypos", ypos_b, 0);
        fall_bad = 0;
        max_delta = 0;
        prev_y = ypos_b;
        for (int k = 1; k <= 69; k++) begin
            @(negedge clk60MHz);
            exp_y = (k <= 39) ? (k * (k + 1)) / 2 : 780 + 40 * (k - 39);
            if (ypos_b !== 12'(exp_y)) fall_bad++;
            if (int'(ypos_b) - int'(prev_y) > max_delta) max_delta = int'(ypos_b) - int'(prev_y);
            prev_y = ypos_b;
            if (k == 39) check("sat_fall_780", ypos_b, 780);
            if (k == 40) check("sat_fall_820", ypos_b, 820);
            if (k == 41) check("sat_fall_860", ypos_b, 860);
        end
        check("sat_fall_path_errors", fall_bad, 0);
        check("sat_fall_max_delta", max_delta, 40);
        @(negedge clk60MHz);
        check("sat_land_ypos", ypos_b, 2000);
        check("sat_land_pulse", landed_b, 1);
        check("sat_land_busy", busy_b, 0);
        @(negedge clk60MHz);
        check("sat_idle_ypos", ypos_b, 768);
        check("sat_land_once", landed_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
